otter_cu_fsm: RTL and testbench

Multi-cycle control state machine for the OTTER RV32I core. It sequences each instruction through fetch, execute and optional writeback, and gates the write enables for the PC, register file, memory and CSR file. It takes machine-mode interrupts between instructions. It sits beside the decoder/ImmGenerator datapath and drives only enables; mux selects stay with the decoder.

---
 rtl/otter_pkg.sv | 48 ++++
 rtl/otter_cu_fsm_if.sv | 45 ++++
 rtl/otter_cu_exec_decode.sv | 56 +++++
 rtl/otter_cu_fsm.sv | 137 +++++++++++++
 tb/tb_otter_cu_fsm.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_pkg
// Description : Shared types for the OTTER multi-cycle control unit:
//               RV32I major opcodes, control-FSM states, the privileged
//               func3 encoding and the ST_EXEC enable bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_OP     = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    // SYSTEM with this func3 is the privileged group; only MRET is honoured.
    localparam logic [2:0] FUNC3_PRIV = 3'b000;

    // Enables produced during ST_EXEC, plus a flag steering the FSM to ST_WB.
    typedef struct packed {
        logic pc_write;
        logic reg_write;
        logic mem_we2;
        logic mem_rden2;
        logic csr_we;
        logic mret;
        logic illegal;
        logic is_load;
    } exec_en_t;

endpackage
`default_nettype wire

// File: rtl/otter_cu_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : otter_cu_fsm_if
// Description : Control-unit <-> datapath bundle.
//               master : the control FSM (consumes decode fields and
//                        interrupt status, drives enables/pulses)
//               slave  : the datapath side
//               Inputs to the FSM : opcode[6:0], func3[2:0], INTR, mie
//               Outputs of the FSM: PCWrite, regWrite, memWE2, memRDEN1,
//                                   memRDEN2, csr_WE, int_taken, mret_exec,
//                                   rst_out, illegal
// Revision    : 1.0 - initial release
// ============================================================================
interface otter_cu_fsm_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       INTR;
    logic       mie;

    logic       PCWrite;
    logic       regWrite;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;
    logic       rst_out;
    logic       illegal;

    modport master (
        input  opcode, func3, INTR, mie,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               csr_WE, int_taken, mret_exec, rst_out, illegal
    );

    modport slave (
        output opcode, func3, INTR, mie,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               csr_WE, int_taken, mret_exec, rst_out, illegal
    );

endinterface
`default_nettype wire

// File: rtl/otter_cu_exec_decode.sv
`default_nettype none
// ============================================================================
// Module      : otter_cu_exec_decode
// Description : Purely combinational map from (opcode, func3) to the enable
//               set asserted in ST_EXEC. Unknown opcodes retire as a NOP
//               (PC advances) and flag illegal.
//   opcode [6:0] in  : ir[6:0]
//   func3  [2:0] in  : ir[14:12]
//   en           out : ST_EXEC enable bundle (exec_en_t)
// Revision    : 1.0 - initial release
// ============================================================================
module otter_cu_exec_decode
    import otter_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    output exec_en_t   en
);

    always_comb begin
        en = '0;
        case (opcode)
            OP_LOAD: begin
                // PC is held until writeback so the load retires atomically.
                en.mem_rden2 = 1'b1;
                en.is_load   = 1'b1;
            end
            OP_STORE: begin
                en.mem_we2  = 1'b1;
                en.pc_write = 1'b1;
            end
            OP_BRANCH: begin
                en.pc_write = 1'b1;
            end
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_IMM: begin
                en.pc_write  = 1'b1;
                en.reg_write = 1'b1;
            end
            OP_SYSTEM: begin
                en.pc_write = 1'b1;
                if (func3 == FUNC3_PRIV) begin
                    en.mret = 1'b1;
                end else begin
                    en.reg_write = 1'b1;
                    en.csr_we    = 1'b1;
                end
            end
            default: begin
                en.pc_write = 1'b1;
                en.illegal  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module      : otter_cu_fsm
// Description : Multi-cycle control FSM for the OTTER RV32I core.
//               INIT -> FETCH -> EXEC [-> WB for loads] [-> INTR] -> FETCH.
//               Drives only write/read enables; datapath mux selects are
//               owned by the decoder.
//   CLK      in  : system clock, rising edge
//   RST      in  : synchronous active-high reset
//   bus      io  : otter_cu_fsm_if.master (decode fields, interrupt status,
//                  enables and one-cycle pulses)
//   INIT_CYCLES  : cycles rst_out stays high after RST drops (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int INIT_CYCLES = 2
)(
    input  logic           CLK,
    input  logic           RST,
    otter_cu_fsm_if.master bus
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    cu_state_t  state;
    logic [3:0] init_cnt;
    exec_en_t   exec_en;
    logic       take_intr;

    otter_cu_exec_decode u_exec_decode (
        .opcode (bus.opcode),
        .func3  (bus.func3),
        .en     (exec_en)
    );

    assign take_intr = bus.INTR & bus.mie;

    // ------------------------------------------------------------------
    // State register and INIT counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state    <= ST_FETCH;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 4'd1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // MRET re-enables interrupts itself; never vector in
                    // the same cycle it restores the PC.
                    if (exec_en.is_load)
                        state <= ST_WB;
                    else if (!exec_en.mret && take_intr)
                        state <= ST_INTR;
                    else
                        state <= ST_FETCH;
                end
                ST_WB: begin
                    state <= take_intr ? ST_INTR : ST_FETCH;
                end
                ST_INTR: begin
                    state <= ST_FETCH;
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. RST overrides everything combinationally so that an
    // in-flight enable (e.g. a store in EXEC) is dropped in the very cycle
    // reset is seen.
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.regWrite  = 1'b0;
        bus.memWE2    = 1'b0;
        bus.memRDEN1  = 1'b0;
        bus.memRDEN2  = 1'b0;
        bus.csr_WE    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        bus.rst_out   = 1'b0;
        bus.illegal   = 1'b0;
        if (RST) begin
            bus.rst_out = 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    bus.rst_out = 1'b1;
                end
                ST_FETCH: begin
                    bus.memRDEN1 = 1'b1;
                end
                ST_EXEC: begin
                    bus.PCWrite   = exec_en.pc_write;
                    bus.regWrite  = exec_en.reg_write;
                    bus.memWE2    = exec_en.mem_we2;
                    bus.memRDEN2  = exec_en.mem_rden2;
                    bus.csr_WE    = exec_en.csr_we;
                    bus.mret_exec = exec_en.mret;
                    bus.illegal   = exec_en.illegal;
                end
                ST_WB: begin
                    bus.regWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                end
                ST_INTR: begin
                    bus.int_taken = 1'b1;
                    bus.PCWrite   = 1'b1;
                end
                default: begin
                    // Unreachable encoding: hold the datapath in reset while
                    // the state register recovers to ST_INIT.
                    bus.rst_out = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_cu_fsm
// Description : Directed self-checking bench for otter_cu_fsm. Each scenario
//               task walks a per-cycle table of inputs and hand-computed
//               expected output vectors.
//               Vector bit order: {PCWrite, regWrite, memWE2, memRDEN1,
//               memRDEN2, csr_WE, int_taken, mret_exec, rst_out, illegal}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    otter_cu_fsm_if bus_if ();

    otter_cu_fsm #(.INIT_CYCLES(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    wire [9:0] outs = {bus_if.PCWrite, bus_if.regWrite, bus_if.memWE2,
                       bus_if.memRDEN1, bus_if.memRDEN2, bus_if.csr_WE,
                       bus_if.int_taken, bus_if.mret_exec, bus_if.rst_out,
                       bus_if.illegal};

    localparam logic [9:0] E_RST  = 10'h002;
    localparam logic [9:0] E_FET  = 10'h040;
    localparam logic [9:0] E_ALU  = 10'h300;
    localparam logic [9:0] E_LDX  = 10'h020;
    localparam logic [9:0] E_WB   = 10'h300;
    localparam logic [9:0] E_ST   = 10'h280;
    localparam logic [9:0] E_INT  = 10'h208;
    localparam logic [9:0] E_CSR  = 10'h310;
    localparam logic [9:0] E_MRET = 10'h204;
    localparam logic [9:0] E_ILL  = 10'h201;
    localparam logic [9:0] E_BR   = 10'h200;

    localparam logic [6:0] O_ADDI = 7'b0010011;
    localparam logic [6:0] O_LW   = 7'b0000011;
    localparam logic [6:0] O_SW   = 7'b0100011;
    localparam logic [6:0] O_SYS  = 7'b1110011;
    localparam logic [6:0] O_BR   = 7'b1100011;
    localparam logic [6:0] O_JAL  = 7'b1101111;
    localparam logic [6:0] O_BAD  = 7'b0000000;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       intr;
        logic       mie;
        logic       rst;
        logic [9:0] exp;
    } vec_t;

    // Apply one cycle of inputs on the falling edge and let the
    // combinational outputs settle before the caller samples them.
    task automatic drive(input vec_t c);
        @(negedge clk);
        rst           = c.rst;
        bus_if.opcode = c.op;
        bus_if.func3  = c.f3;
        bus_if.INTR   = c.intr;
        bus_if.mie    = c.mie;
        #1;
    endtask

    task automatic test_reset();
        vec_t v [5] = '{
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b1, E_RST},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b1, E_RST},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b1, E_RST},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_RST},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_RST}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    // INTR/mie high during FETCH must be ignored.
    task automatic test_addi_lw();
        vec_t v [5] = '{
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_ADDI, 3'd0, 1'b0, 1'b1, 1'b0, E_ALU},
            '{O_LW,   3'd2, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_LW,   3'd2, 1'b0, 1'b1, 1'b0, E_LDX},
            '{O_LW,   3'd2, 1'b0, 1'b1, 1'b0, E_WB}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL addi_lw cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    task automatic test_store_intr();
        vec_t v [5] = '{
            '{O_SW, 3'd2, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_SW, 3'd2, 1'b1, 1'b1, 1'b0, E_ST},
            '{O_SW, 3'd2, 1'b1, 1'b1, 1'b0, E_INT},
            '{O_SW, 3'd2, 1'b1, 1'b0, 1'b0, E_FET},
            '{O_SW, 3'd2, 1'b1, 1'b0, 1'b0, E_ST}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL store_intr cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    // MRET blocks the interrupt; the following ADDI takes it.
    task automatic test_csr_mret();
        vec_t v [7] = '{
            '{O_SYS,  3'd1, 1'b0, 1'b0, 1'b0, E_FET},
            '{O_SYS,  3'd1, 1'b0, 1'b0, 1'b0, E_CSR},
            '{O_SYS,  3'd0, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_SYS,  3'd0, 1'b1, 1'b1, 1'b0, E_MRET},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_ALU},
            '{O_ADDI, 3'd0, 1'b1, 1'b1, 1'b0, E_INT}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL csr_mret cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    task automatic test_illegal_branch();
        vec_t v [6] = '{
            '{O_BAD, 3'd0, 1'b0, 1'b1, 1'b0, E_FET},
            '{O_BAD, 3'd0, 1'b0, 1'b1, 1'b0, E_ILL},
            '{O_BR,  3'd0, 1'b0, 1'b1, 1'b0, E_FET},
            '{O_BR,  3'd0, 1'b0, 1'b1, 1'b0, E_BR},
            '{O_JAL, 3'd0, 1'b0, 1'b1, 1'b0, E_FET},
            '{O_JAL, 3'd0, 1'b0, 1'b1, 1'b0, E_ALU}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL illegal_branch cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    // Interrupt taken after a load's writeback.
    task automatic test_load_intr();
        vec_t v [4] = '{
            '{O_LW, 3'd2, 1'b1, 1'b1, 1'b0, E_FET},
            '{O_LW, 3'd2, 1'b1, 1'b1, 1'b0, E_LDX},
            '{O_LW, 3'd2, 1'b1, 1'b1, 1'b0, E_WB},
            '{O_LW, 3'd2, 1'b1, 1'b1, 1'b0, E_INT}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL load_intr cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    // RST during the EXEC of a store drops memWE2/PCWrite immediately.
    task automatic test_rst_mid();
        vec_t v [6] = '{
            '{O_SW,   3'd2, 1'b0, 1'b0, 1'b0, E_FET},
            '{O_SW,   3'd2, 1'b0, 1'b0, 1'b1, E_RST},
            '{O_SW,   3'd2, 1'b0, 1'b0, 1'b0, E_RST},
            '{O_SW,   3'd2, 1'b0, 1'b0, 1'b0, E_RST},
            '{O_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, E_FET},
            '{O_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, E_ALU}
        };
        foreach (v[i]) begin
            drive(v[i]);
            total++;
            if (outs !== v[i].exp) begin
                bad++;
                $display("FAIL rst_mid cyc%0d: got %h want %h", i, outs, v[i].exp);
            end
        end
    endtask

    initial begin
        bus_if.opcode = O_ADDI;
        bus_if.func3  = 3'd0;
        bus_if.INTR   = 1'b0;
        bus_if.mie    = 1'b0;
        test_reset();
        test_addi_lw();
        test_store_intr();
        test_csr_mret();
        test_illegal_branch();
        test_load_intr();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
